// File: rtl/mipi_lane_hs_tx_sequencer_if.sv
// Payload byte stream into the D-PHY lane sequencer (valid/ready, with end-of-burst marker).
`timescale 1ns/1ps
interface mipi_lane_hs_tx_sequencer_if;
    logic [7:0] s_data;
    logic       s_valid;
    logic       s_last;
    logic       s_ready;

    modport master (
        output s_data,
        output s_valid,
        output s_last,
        input  s_ready
    );

    modport slave (
        input  s_data,
        input  s_valid,
        input  s_last,
        output s_ready
    );
endinterface

// File: rtl/mipi_lane_hs_tx_sequencer.sv
// Transmit sequencer for D-PHY data lane 0:
// LP11 -> LP01 -> LP00 -> HS-zero -> sync -> payload -> trail -> LP11.
// All outputs are registered, and a single 8-bit down-counter times every timed state.
// Optional EoT packet insertion before the trail: define MIPI_TX_EOTP_EN.
`timescale 1ns/1ps
module mipi_lane_hs_tx_sequencer #(
    parameter logic [7:0] T_LPX        = 8'd4,
    parameter logic [7:0] T_HS_PREPARE = 8'd3,
    parameter logic [7:0] T_HS_ZERO    = 8'd6,
    parameter logic [7:0] T_HS_TRAIL   = 8'd5,
    parameter logic [7:0] T_HS_EXIT    = 8'd4
) (
    input  logic                              sys_clk,
    input  logic                              sys_rst,
    mipi_lane_hs_tx_sequencer_if.slave        s_if,
    output logic [1:0]                        lp_lane_data0,
    output logic                              hs_oe,
    output logic [7:0]                        hs_data,
    output logic                              busy,
    output logic                              err_underrun
);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_RQST,
        ST_PREPARE,
        ST_ZERO,
        ST_SYNC,
        ST_DATA,
`ifdef MIPI_TX_EOTP_EN
        ST_EOTP,
`endif
        ST_TRAIL,
        ST_EXIT
    } state_t;

    localparam logic [7:0] SYNC_BYTE = 8'hB8;

`ifdef MIPI_TX_EOTP_EN
    // The burst tail begins with the 4-byte EoT packet; the counter indexes its bytes.
    localparam state_t     ST_TAIL   = ST_EOTP;
    localparam logic [7:0] TAIL_LOAD = 8'd3;

    function automatic logic [7:0] f_eotp_byte(input logic [7:0] cnt);
        logic [7:0] b;
        case (cnt)
            8'd3:       b = 8'h08;
            8'd2, 8'd1: b = 8'h0F;
            default:    b = 8'h01;
        endcase
        return b;
    endfunction
`else
    localparam state_t     ST_TAIL   = ST_TRAIL;
    localparam logic [7:0] TAIL_LOAD = T_HS_TRAIL - 8'd1;
`endif

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nxt;

    logic [1:0] r_lp;
    logic       r_hs_oe;
    logic [7:0] r_hs_data;
    logic       r_s_ready;
    logic       r_busy;
    logic       r_err;

    logic [1:0] w_lp_nxt;
    logic       w_hs_oe_nxt;
    logic [7:0] w_hs_data_nxt;
    logic       w_s_ready_nxt;
    logic       w_busy_nxt;
    logic       w_err_nxt;
    logic       w_accept;
    logic [7:0] w_trail_byte;

    assign w_accept     = s_if.s_valid & r_s_ready;
    // Trail is the inverse of the last bit put on the wire (bit 7, since the PHY sends LSB first).
    assign w_trail_byte = {8{~r_hs_data[7]}};

    // State and timing counter register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state, counter reload and next output values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_hs_data_nxt = r_hs_data;
        w_s_ready_nxt = 1'b0;
        w_err_nxt     = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (s_if.s_valid) begin
                    w_state_nxt   = ST_RQST;
                    w_cnt_nxt     = T_LPX - 8'd1;
                    w_hs_data_nxt = 8'h00;
                end
            end
            ST_RQST: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_PREPARE;
                    w_cnt_nxt   = T_HS_PREPARE - 8'd1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_PREPARE: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = ST_ZERO;
                    w_cnt_nxt     = T_HS_ZERO - 8'd1;
                    w_hs_data_nxt = 8'h00;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_ZERO: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = ST_SYNC;
                    w_cnt_nxt     = '0;
                    w_hs_data_nxt = SYNC_BYTE;
                    w_s_ready_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            // SYNC and DATA share the payload handshake. With s_ready low in DATA the
            // final byte is on the wire; with s_ready high and no byte it is an underrun.
            ST_SYNC, ST_DATA: begin
                if (w_accept) begin
                    w_state_nxt   = ST_DATA;
                    w_hs_data_nxt = s_if.s_data;
                    w_s_ready_nxt = ~s_if.s_last;
                end else begin
                    w_state_nxt = ST_TAIL;
                    w_cnt_nxt   = TAIL_LOAD;
                    w_err_nxt   = r_s_ready;
`ifdef MIPI_TX_EOTP_EN
                    w_hs_data_nxt = f_eotp_byte(TAIL_LOAD);
`else
                    w_hs_data_nxt = w_trail_byte;
`endif
                end
            end
`ifdef MIPI_TX_EOTP_EN
            ST_EOTP: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = ST_TRAIL;
                    w_cnt_nxt     = T_HS_TRAIL - 8'd1;
                    w_hs_data_nxt = w_trail_byte;
                end else begin
                    w_cnt_nxt     = r_cnt - 8'd1;
                    w_hs_data_nxt = f_eotp_byte(r_cnt - 8'd1);
                end
            end
`endif
            ST_TRAIL: begin
                if (r_cnt == '0) begin
                    w_state_nxt   = ST_EXIT;
                    w_cnt_nxt     = T_HS_EXIT - 8'd1;
                    w_hs_data_nxt = 8'h00;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            ST_EXIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nxt   = ST_IDLE;
                w_cnt_nxt     = '0;
                w_hs_data_nxt = 8'h00;
            end
        endcase

        case (w_state_nxt)
            ST_IDLE, ST_EXIT: w_lp_nxt = 2'b11;
            ST_RQST:          w_lp_nxt = 2'b01;
            default:          w_lp_nxt = 2'b00;
        endcase

        case (w_state_nxt)
            ST_IDLE, ST_RQST, ST_PREPARE, ST_EXIT: w_hs_oe_nxt = 1'b0;
            default:                               w_hs_oe_nxt = 1'b1;
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // Output registers, loaded from the values for the state being entered.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_lp      <= 2'b11;
            r_hs_oe   <= 1'b0;
            r_hs_data <= 8'h00;
            r_s_ready <= 1'b0;
            r_busy    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_lp      <= w_lp_nxt;
            r_hs_oe   <= w_hs_oe_nxt;
            r_hs_data <= w_hs_data_nxt;
            r_s_ready <= w_s_ready_nxt;
            r_busy    <= w_busy_nxt;
            r_err     <= w_err_nxt;
        end
    end

    assign lp_lane_data0 = r_lp;
    assign hs_oe         = r_hs_oe;
    assign hs_data       = r_hs_data;
    assign busy          = r_busy;
    assign err_underrun  = r_err;
    assign s_if.s_ready  = r_s_ready;

endmodule

// File: doc/mipi_lane_hs_tx_sequencer.md
# mipi_lane_hs_tx_sequencer

Transmit-side lane sequencer for one MIPI D-PHY data lane (data0), used to generate DSI traffic towards the panel under test. It drives the LP line states and the HS byte stream through the full HS entry, burst and exit sequence: LP11 → LP01 → LP00 → HS-zero → sync → payload → trail → LP11. The byte stream comes in over a valid/ready interface. Its LP and HS outputs connect to the D-PHY TX primitive.

## Interface
Parameters (all in sys_clk cycles, 8-bit, legal range 1..255):
- T_LPX, 4: duration of LP01 (HS request).
- T_HS_PREPARE, 3: duration of LP00 before the HS driver is enabled.
- T_HS_ZERO, 6: number of 0x00 HS bytes before sync.
- T_HS_TRAIL, 5: number of trail bytes.
- T_HS_EXIT, 4: minimum LP11 time after the burst before the next request.

Ports:
- sys_clk, input, 1: single clock for the block.
- sys_rst, input, 1: reset, asynchronous and active-high.
- s_data, input, 8: payload byte. Sent LSB first by the PHY.
- s_valid, input, 1: payload byte valid.
- s_last, input, 1: marks the final byte of the burst.
- s_ready, output, 1: byte accepted when s_valid && s_ready.
- lp_lane_data0, output, 2: LP line state {Dp, Dn}.
- hs_oe, output, 1: HS driver enable.
- hs_data, output, 8: HS byte to the serializer.
- busy, output, 1: high in every state except IDLE.
- err_underrun, output, 1: one-cycle pulse when s_valid is low while a byte is required.

## Operation
- Reset values: lp_lane_data0=2'b11, hs_oe=0, hs_data=8'h00, s_ready=0, busy=0, err_underrun=0, state=IDLE, counter=0.
- All outputs are registered. A single 8-bit down-counter times every timed state. The counter loads PARAM-1 on state entry, and the state is left on the cycle the counter reads 0.
- State IDLE (LP11): leaves when s_valid=1. s_data is not consumed.
- State RQST (LP01, T_LPX cycles) → PREPARE.
- State PREPARE (LP00, T_HS_PREPARE cycles) → ZERO.
- State ZERO: hs_oe=1, hs_data=0x00, lp=00, for T_HS_ZERO cycles → SYNC.
- State SYNC (1 cycle): hs_data=0xB8, s_ready=1 → DATA.
- State DATA: s_ready=1. Each accepted byte appears on hs_data on the next cycle.
  - An accepted byte with s_last=1 drops s_ready. That byte is output, then the block goes to EOTP (macro defined) or TRAIL.
  - If s_valid=0 while s_ready=1, that is an underrun. err_underrun pulses, and TRAIL starts on the next cycle. The last transmitted byte is treated as final.
- State TRAIL: hs_data = {8{~b7}}, where b7 is bit 7 of the last HS byte transmitted (the final bit on the wire). Lasts T_HS_TRAIL cycles → EXIT.
- State EXIT: hs_oe=0, lp=11, for T_HS_EXIT cycles → IDLE. s_valid is ignored during EXIT.
- HS bytes are never stalled once hs_oe=1. HS has no backpressure.
- Reset mid-burst: all outputs take their reset values immediately (asynchronous). The interrupted burst is discarded.

## Timing
- Let s_valid rise with IDLE sampled at edge k:
  - lp=01 from k+1 for T_LPX cycles.
  - lp=00 for T_HS_PREPARE cycles.
  - hs_oe rises after that.
- Latency from request to first payload byte on hs_data = T_LPX + T_HS_PREPARE + T_HS_ZERO + 2 cycles. The first byte is accepted in SYNC and appears one cycle later.
- Payload throughput is 1 byte per cycle, with no gaps.
- busy falls on the cycle the block returns to IDLE.
- The earliest next RQST is 1 cycle after IDLE is entered.

## Configuration
- MIPI_TX_EOTP_EN defined:
  - After the final payload byte, state EOTP emits the EoT packet 0x08, 0x0F, 0x0F, 0x01 over 4 cycles, then TRAIL. Trail is therefore 0xFF.
  - An underrun also emits the EoTp before TRAIL.
- MIPI_TX_EOTP_EN undefined: the EOTP state does not exist, and TRAIL follows the final payload byte directly.

## Test plan
- Defaults, 3-byte burst {0x11,0x22,0xA3}, last on 0xA3, macro off:
  - lp = 11, then 01×4, then 00×3.
  - hs_data = 00×6, B8, 11, 22, A3, then 00×5 (bit7 of 0xA3 is 1).
  - Then lp=11 for 4 cycles, busy=0, err_underrun never high.
- Same burst with MIPI_TX_EOTP_EN: hs_data after A3 is 08, 0F, 0F, 01, then FF×5.
- 4-byte request with s_valid dropped after the 2nd byte {0x7F,0x05}:
  - err_underrun pulses once.
  - hs_data after 05 is FF×5 (bit7 of 0x05 is 0).
  - Return to LP11.
- Back-to-back bursts with s_valid held high:
  - The second RQST starts exactly T_HS_EXIT+1 cycles after hs_oe falls.
  - s_ready is low outside SYNC/DATA.
- sys_rst asserted during ZERO and again during DATA:
  - lp=11, hs_oe=0, s_ready=0, busy=0 immediately, without waiting for a clock edge.
  - After release, a new burst completes normally.
- Parameters T_LPX=1, T_HS_PREPARE=1, T_HS_ZERO=1, T_HS_TRAIL=1, T_HS_EXIT=1, 1-byte burst 0x80: each timed state lasts exactly 1 cycle, and trail is 0x00.
